alu_resp_misr: RTL and testbench

ALU_RESP_MISR -- requirements
Module: alu_resp_misr

---
 rtl/alu_resp_misr.sv | 111 +++++++++++
 tb/tb_alu_resp_misr.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_resp_misr.sv
// Response compactor for ALU self-test: folds masked zout vectors into a 16-bit MISR,
// counts per-pattern compare failures and issues a pass/fail verdict per session.
module alu_resp_misr #(
  parameter int unsigned NOUT = 2,
  parameter int unsigned SIGW = 16,
  parameter int unsigned CNTW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [CNTW-1:0] num_pat,
  input  logic [SIGW-1:0] golden_sig,
  input  logic            resp_valid,
  input  logic [NOUT-1:0] resp,
  input  logic [NOUT-1:0] xpct,
  input  logic [NOUT-1:0] mask,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [SIGW-1:0] sig,
  output logic [CNTW-1:0] pat_cnt,
  output logic [CNTW-1:0] fail_cnt,
  output logic [CNTW-1:0] first_fail
);

  localparam logic [SIGW-1:0] Poly = SIGW'(16'h1021);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state;
  logic [CNTW-1:0] num_pat_q;
  logic [SIGW-1:0] golden_q;

  logic [NOUT-1:0] m;
  logic            pat_fail;
  logic [SIGW-1:0] sig_nxt;
  logic [CNTW-1:0] pat_nxt;
  logic [CNTW-1:0] fail_nxt;

  always_comb begin
    m        = resp & mask;
    pat_fail = |((resp ^ xpct) & mask);
    sig_nxt  = {sig[SIGW-2:0], 1'b0} ^ (sig[SIGW-1] ? Poly : '0) ^ SIGW'(m);
    pat_nxt  = pat_cnt + CNTW'(1);
    // Saturate rather than wrap so a long failing session never reads as clean
    fail_nxt = (pat_fail && (fail_cnt != '1)) ? fail_cnt + CNTW'(1) : fail_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      sig        <= '1;
      pat_cnt    <= '0;
      fail_cnt   <= '0;
      first_fail <= '1;
      num_pat_q  <= '0;
      golden_q   <= '0;
    end else begin
      case (state)
        StIdle, StDone: begin
          if (start) begin
            sig        <= '1;
            pat_cnt    <= '0;
            fail_cnt   <= '0;
            first_fail <= '1;
            num_pat_q  <= num_pat;
            golden_q   <= golden_sig;
            if (num_pat != '0) begin
              state <= StRun;
              busy  <= 1'b1;
              done  <= 1'b0;
              pass  <= 1'b0;
            end else begin
              // Empty session: signature stays at its seed value
              state <= StDone;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (golden_sig == '1);
            end
          end
        end
        StRun: begin
          if (resp_valid) begin
            sig      <= sig_nxt;
            pat_cnt  <= pat_nxt;
            fail_cnt <= fail_nxt;
            // fail_cnt never returns to zero within a session, so it marks the first fail
            if (pat_fail && (fail_cnt == '0)) begin
              first_fail <= pat_cnt;
            end
            if (pat_nxt == num_pat_q) begin
              state <= StDone;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (sig_nxt == golden_q) && (fail_nxt == '0);
            end
          end
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_resp_misr.sv
// Directed self-checking bench for alu_resp_misr with immediate assertions.
module tb_alu_resp_misr;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  num_pat;
  logic [15:0] golden_sig;
  logic        resp_valid;
  logic [1:0]  resp;
  logic [1:0]  xpct;
  logic [1:0]  mask;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] sig;
  logic [7:0]  pat_cnt;
  logic [7:0]  fail_cnt;
  logic [7:0]  first_fail;

  int checks = 0;
  int errors = 0;

  alu_resp_misr #(
    .NOUT(2),
    .SIGW(16),
    .CNTW(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_pat   (num_pat),
    .golden_sig(golden_sig),
    .resp_valid(resp_valid),
    .resp      (resp),
    .xpct      (xpct),
    .mask      (mask),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .sig       (sig),
    .pat_cnt   (pat_cnt),
    .fail_cnt  (fail_cnt),
    .first_fail(first_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference MISR step: shift left, feed back 0x1021 on MSB, xor in masked response
  function automatic logic [15:0] misr(input logic [15:0] s, input logic [1:0] mv);
    misr = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {14'h0, mv};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [7:0] n, input logic [15:0] g);
    start      = 1'b1;
    num_pat    = n;
    golden_sig = g;
    tick();
    start      = 1'b0;
  endtask

  task automatic send(input logic [1:0] r, input logic [1:0] x, input logic [1:0] mk);
    resp_valid = 1'b1;
    resp       = r;
    xpct       = x;
    mask       = mk;
    tick();
    resp_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_pass"}, 32'(pass), 32'h0);
    chk({tag, "_sig"}, 32'(sig), 32'hFFFF);
    chk({tag, "_pat"}, 32'(pat_cnt), 32'h0);
    chk({tag, "_fail"}, 32'(fail_cnt), 32'h0);
    chk({tag, "_ff"}, 32'(first_fail), 32'hFF);
  endtask

  logic [15:0] exp_sig;
  logic [1:0]  vr [4];
  logic [1:0]  vm [4];

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    num_pat    = '0;
    golden_sig = '0;
    resp_valid = 1'b0;
    resp       = '0;
    xpct       = '0;
    mask       = '0;
    tick();
    tick();
    chk_reset_vals("rst");
    rst_n = 1'b1;
    tick();
    // resp_valid in IDLE must not disturb anything
    send(2'b11, 2'b00, 2'b11);
    chk_reset_vals("idle_valid");

    // Single passing pattern
    do_start(8'd1, 16'hEFDD);
    chk("t1_busy", 32'(busy), 32'h1);
    chk("t1_done0", 32'(done), 32'h0);
    send(2'b10, 2'b10, 2'b11);
    chk("t1_sig", 32'(sig), 32'hEFDD);
    chk("t1_done", 32'(done), 32'h1);
    chk("t1_busy0", 32'(busy), 32'h0);
    chk("t1_pass", 32'(pass), 32'h1);
    chk("t1_fail", 32'(fail_cnt), 32'h0);
    chk("t1_ff", 32'(first_fail), 32'hFF);
    chk("t1_pat", 32'(pat_cnt), 32'h1);

    // Patterns 2 and 3 fail; golden matches signature but verdict must still fail
    exp_sig = misr(misr(misr(16'hFFFF, 2'b01), 2'b01), 2'b10);
    do_start(8'd3, exp_sig);
    send(2'b01, 2'b01, 2'b11);
    send(2'b01, 2'b00, 2'b11);
    send(2'b10, 2'b11, 2'b11);
    chk("t2_sig", 32'(sig), 32'(exp_sig));
    chk("t2_fail", 32'(fail_cnt), 32'h2);
    chk("t2_ff", 32'(first_fail), 32'h1);
    chk("t2_pass", 32'(pass), 32'h0);
    chk("t2_done", 32'(done), 32'h1);

    // Fully masked responses compact zero; 0xFFFF -> 0xEFDF -> 0xCF9F
    do_start(8'd2, 16'hCF9F);
    send(2'b11, 2'b00, 2'b00);
    chk("t3_mid_sig", 32'(sig), 32'hEFDF);
    send(2'b11, 2'b00, 2'b00);
    chk("t3_sig", 32'(sig), 32'hCF9F);
    chk("t3_fail", 32'(fail_cnt), 32'h0);
    chk("t3_pass", 32'(pass), 32'h1);

    // Empty sessions, including DONE->DONE restart
    do_start(8'd0, 16'hFFFF);
    chk("t4_done", 32'(done), 32'h1);
    chk("t4_busy", 32'(busy), 32'h0);
    chk("t4_pass", 32'(pass), 32'h1);
    chk("t4_pat", 32'(pat_cnt), 32'h0);
    chk("t4_sig", 32'(sig), 32'hFFFF);
    do_start(8'd0, 16'h1234);
    chk("t4b_done", 32'(done), 32'h1);
    chk("t4b_pass", 32'(pass), 32'h0);

    // Gapped run with a stray start mid-RUN and resp_valid after DONE
    vr[0] = 2'b01; vr[1] = 2'b11; vr[2] = 2'b10; vr[3] = 2'b00;
    vm[0] = 2'b11; vm[1] = 2'b01; vm[2] = 2'b11; vm[3] = 2'b10;
    exp_sig = 16'hFFFF;
    for (int i = 0; i < 4; i++) exp_sig = misr(exp_sig, vr[i] & vm[i]);
    do_start(8'd4, exp_sig);
    for (int i = 0; i < 4; i++) begin
      send(vr[i], vr[i], vm[i]);
      if (i == 1) begin
        do_start(8'd1, 16'h0000);
        chk("t5_start_ign_busy", 32'(busy), 32'h1);
        chk("t5_start_ign_pat", 32'(pat_cnt), 32'h2);
        tick();
      end else if (i < 3) begin
        tick();
        tick();
        chk("t5_gap_pat", 32'(pat_cnt), 32'(i + 1));
      end
    end
    chk("t5_sig", 32'(sig), 32'(exp_sig));
    chk("t5_done", 32'(done), 32'h1);
    chk("t5_pass", 32'(pass), 32'h1);
    chk("t5_pat", 32'(pat_cnt), 32'h4);
    send(2'b11, 2'b00, 2'b11);
    chk("t5_post_sig", 32'(sig), 32'(exp_sig));
    chk("t5_post_pat", 32'(pat_cnt), 32'h4);
    chk("t5_post_fail", 32'(fail_cnt), 32'h0);
    chk("t5_post_pass", 32'(pass), 32'h1);

    // Asynchronous reset mid-session, then a clean session
    do_start(8'd5, 16'h0000);
    send(2'b01, 2'b00, 2'b11);
    send(2'b10, 2'b00, 2'b11);
    chk("t6_pre_fail", 32'(fail_cnt), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("t6_rst");
    tick();
    rst_n = 1'b1;
    tick();
    do_start(8'd1, 16'hEFDD);
    send(2'b10, 2'b10, 2'b11);
    chk("t6_sig", 32'(sig), 32'hEFDD);
    chk("t6_pass", 32'(pass), 32'h1);
    chk("t6_ff", 32'(first_fail), 32'hFF);
    chk("t6_done", 32'(done), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
